// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - register-file operand fetch, ALU issue and write-back sequencer
module alu_operand_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [3:0]        alu_instruction,
    input  logic [DATA_W-1:0] alu_F,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int REGS = 1 << REG_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] rf [REGS];
    logic [REG_AW-1:0] rd_q;
    logic [DATA_W-1:0] result_q;
    logic              handshake;

    assign cmd_ready = (state == IDLE) && !rst;
    assign handshake = cmd_valid && cmd_ready;
    assign wb_valid  = (state == WB) && !rst;
    assign wb_rd     = rd_q;
    assign wb_data   = result_q;
    assign dbg_data  = rf[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write-back is ordered after the load port so it wins on a shared target.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ld_valid) begin
                rf[ld_addr] <= ld_data;
            end
            if (wb_valid) begin
                rf[rd_q] <= result_q;
            end
        end
    end

    // Operands read rf before this edge's writes, so same-cycle loads are not forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_A           <= '0;
            alu_B           <= '0;
            alu_instruction <= '0;
            rd_q            <= '0;
        end else if (handshake) begin
            alu_A           <= rf[cmd_rs1];
            alu_B           <= rf[cmd_rs2];
            alu_instruction <= cmd_op;
            rd_q            <= cmd_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (state == EXEC) begin
            result_q <= alu_F;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [1:0] cmd_rd;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [3:0] alu_instruction;
    logic [7:0] alu_F;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_rf [4];

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(8), .REG_AW(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_A(alu_A), .alu_B(alu_B), .alu_instruction(alu_instruction), .alu_F(alu_F),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ALU stub: opcode 0 is the add the scenarios rely on; others widen random coverage.
    always_comb begin
        case (alu_instruction)
            4'd0:    alu_F = alu_A + alu_B;
            4'd1:    alu_F = alu_A - alu_B;
            4'd2:    alu_F = alu_A ^ alu_B;
            default: alu_F = alu_A & alu_B;
        endcase
    end

    function automatic logic [7:0] expected_result(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        case (op)
            4'd0:    r = (int'(a) + int'(b)) % 256;
            4'd1:    r = (int'(a) - int'(b) + 256) % 256;
            4'd2:    r = int'(a ^ b);
            default: r = int'(a & b);
        endcase
        return 8'(r);
    endfunction

    task automatic do_ld(input logic [1:0] addr, input logic [7:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        model_rf[addr] = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        checks++; if (alu_A !== 8'h00) begin errors++; $display("FAIL reset_alu_A got %h exp 00", alu_A); end
        checks++; if (alu_B !== 8'h00) begin errors++; $display("FAIL reset_alu_B got %h exp 00", alu_B); end
        checks++; if (alu_instruction !== 4'h0) begin errors++; $display("FAIL reset_alu_instruction got %h exp 0", alu_instruction); end
        checks++; if (wb_data !== 8'h00) begin errors++; $display("FAIL reset_wb_data got %h exp 00", wb_data); end
        checks++; if (wb_rd !== 2'd0) begin errors++; $display("FAIL reset_wb_rd got %0d exp 0", wb_rd); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_rf[%0d] got %h exp 00", i, dbg_data); end
        end
        rst = 1'b0; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [1:0] rd, input logic hs_ld, input logic [1:0] hs_addr, input logic [7:0] hs_data,
                           input logic wb_ld, input logic [1:0] wb_addr, input logic [7:0] wb_ld_data);
        logic [7:0] exp_a, exp_b, exp_f;
        exp_a = model_rf[rs1];
        exp_b = model_rf[rs2];
        exp_f = expected_result(op, exp_a, exp_b);
        cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
        ld_valid = hs_ld; ld_addr = hs_addr; ld_data = hs_data;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ready got %b exp 1", tag, cmd_ready); end
        @(posedge clk); #1;
        if (hs_ld) model_rf[hs_addr] = hs_data;
        ld_valid = 1'b0;
        // Held-high command with scrambled fields must be ignored while busy.
        cmd_op = 4'($urandom_range(0, 15)); cmd_rs1 = 2'($urandom_range(0, 3));
        cmd_rs2 = 2'($urandom_range(0, 3)); cmd_rd = 2'($urandom_range(0, 3));
        checks++; if (alu_A !== exp_a) begin errors++; $display("FAIL %s alu_A got %h exp %h", tag, alu_A, exp_a); end
        checks++; if (alu_B !== exp_b) begin errors++; $display("FAIL %s alu_B got %h exp %h", tag, alu_B, exp_b); end
        checks++; if (alu_instruction !== op) begin errors++; $display("FAIL %s alu_instruction got %h exp %h", tag, alu_instruction, op); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s exec_ready got %b exp 0", tag, cmd_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL %s exec_wb_valid got %b exp 0", tag, wb_valid); end
        @(posedge clk); #1;
        ld_valid = wb_ld; ld_addr = wb_addr; ld_data = wb_ld_data;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL %s wb_valid got %b exp 1", tag, wb_valid); end
        checks++; if (wb_rd !== rd) begin errors++; $display("FAIL %s wb_rd got %0d exp %0d", tag, wb_rd, rd); end
        checks++; if (wb_data !== exp_f) begin errors++; $display("FAIL %s wb_data got %h exp %h", tag, wb_data, exp_f); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s wb_ready got %b exp 0", tag, cmd_ready); end
        checks++; if (alu_A !== exp_a) begin errors++; $display("FAIL %s alu_A_hold got %h exp %h", tag, alu_A, exp_a); end
        @(posedge clk); #1;
        ld_valid = 1'b0; cmd_valid = 1'b0;
        if (wb_ld) model_rf[wb_addr] = wb_ld_data;
        model_rf[rd] = exp_f;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL %s post_wb_valid got %b exp 0", tag, wb_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s post_ready got %b exp 1", tag, cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++; if (dbg_data !== model_rf[i]) begin errors++; $display("FAIL %s rf[%0d] got %h exp %h", tag, i, dbg_data, model_rf[i]); end
        end
    endtask

    task automatic test_directed();
        do_ld(2'd1, 8'h12);
        do_ld(2'd2, 8'h34);
        run_cmd("add_r1_r2", 4'd0, 2'd1, 2'd2, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        checks++; if (model_rf[3] !== 8'h46) begin errors++; $display("FAIL add_r1_r2_model got %h exp 46", model_rf[3]); end
        do_ld(2'd0, 8'hFF);
        run_cmd("self_r0", 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        run_cmd("wb_beats_ld", 4'd0, 2'd1, 2'd2, 2'd2, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'hAA);
        do_ld(2'd1, 8'h01);
        run_cmd("no_forward", 4'd0, 2'd1, 2'd2, 2'd3, 1'b1, 2'd1, 8'h05, 1'b0, 2'd0, 8'h00);
        run_cmd("split_targets", 4'd0, 2'd1, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h5C);
    endtask

    task automatic test_reset_in_exec();
        do_ld(2'd1, 8'h33);
        do_ld(2'd2, 8'h44);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2; cmd_rd = 2'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1; ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 8'h77;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_wb_valid got %b exp 0", wb_valid); end
        @(posedge clk); #1;
        rst = 1'b0; ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) model_rf[i] = 8'h00;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_ready got %b exp 1", cmd_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_wb_after got %b exp 0", wb_valid); end
        checks++; if (alu_A !== 8'h00) begin errors++; $display("FAIL rst_exec_alu_A got %h exp 00", alu_A); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL rst_exec_rf[%0d] got %h exp 00", i, dbg_data); end
        end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_wb_late got %b exp 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        int         hs_cyc [8];
        int         hs_n;
        int         wb_n;
        logic [7:0] exp_f;
        hs_n = 0; wb_n = 0;
        do_ld(2'd1, 8'($urandom_range(0, 255)));
        do_ld(2'd2, 8'($urandom_range(0, 255)));
        exp_f = expected_result(4'd0, model_rf[1], model_rf[2]);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rs1 = 2'd1; cmd_rs2 = 2'd2; cmd_rd = 2'd3;
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cmd_valid && cmd_ready && hs_n < 8) begin
                hs_cyc[hs_n] = cyc;
                hs_n++;
            end
            if (wb_valid) begin
                wb_n++;
                checks++; if (wb_data !== exp_f) begin errors++; $display("FAIL b2b_wb_data got %h exp %h", wb_data, exp_f); end
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        model_rf[3] = exp_f;
        checks++; if (hs_n !== 3) begin errors++; $display("FAIL b2b_handshakes got %0d exp 3", hs_n); end
        checks++; if (wb_n !== 3) begin errors++; $display("FAIL b2b_writebacks got %0d exp 3", wb_n); end
        if (hs_n >= 3) begin
            checks++; if (hs_cyc[1] - hs_cyc[0] !== 3) begin errors++; $display("FAIL b2b_spacing01 got %0d exp 3", hs_cyc[1] - hs_cyc[0]); end
            checks++; if (hs_cyc[2] - hs_cyc[1] !== 3) begin errors++; $display("FAIL b2b_spacing12 got %0d exp 3", hs_cyc[2] - hs_cyc[1]); end
        end
        dbg_addr = 2'd3; #1;
        checks++; if (dbg_data !== model_rf[3]) begin errors++; $display("FAIL b2b_rf3 got %h exp %h", dbg_data, model_rf[3]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) do_ld(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            run_cmd("random", 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_in_exec();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the operand/result width and matching the ALU A/B/F width.
REQ-002 The module SHALL have parameter REG_AW, default 2, giving the register-file address width (4 entries).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  stage can accept a command.
REQ-007 cmd_op  input  4  ALU instruction code, passed through unmodified.
REQ-008 cmd_rs1, cmd_rs2, cmd_rd  input  REG_AW each  source A, source B and destination register indices.
REQ-009 ld_valid, ld_addr, ld_data  input  1 / REG_AW / DATA_W  direct register-file write port.
REQ-010 alu_A, alu_B  output  DATA_W  registered operands driven to the ALU.
REQ-011 alu_instruction  output  4  registered opcode driven to the ALU.
REQ-012 alu_F  input  DATA_W  combinational ALU result.
REQ-013 wb_valid, wb_rd, wb_data  output  1 / REG_AW / DATA_W  write-back strobe, destination and result.
REQ-014 dbg_addr input REG_AW, dbg_data output DATA_W  combinational register-file read for observation.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and WB; after reset the state is IDLE.
REQ-016 cmd_ready SHALL be 1 exactly when state is IDLE and rst is 0.
REQ-017 A handshake (cmd_valid & cmd_ready) SHALL latch rf[cmd_rs1] into alu_A, rf[cmd_rs2] into alu_B, cmd_op into alu_instruction, cmd_rd into an internal rd register, and move IDLE->EXEC.
REQ-018 Operands captured at a handshake SHALL be the register values before any write in that same cycle; same-cycle ld writes are not forwarded.
REQ-019 In EXEC, alu_F SHALL be sampled into the result register and the state SHALL move EXEC->WB.
REQ-020 In WB, wb_valid SHALL be 1, wb_data SHALL equal the sampled result, wb_rd SHALL equal the latched rd, rf[rd] SHALL be written, and the state SHALL move WB->IDLE.
REQ-021 Latency SHALL be exactly 2 cycles from the handshake edge to the wb_valid cycle; throughput SHALL be one command per 3 cycles.
REQ-022 alu_A, alu_B and alu_instruction SHALL hold their values outside a handshake cycle.
REQ-023 wb_valid SHALL be 0 in every state other than WB.
REQ-024 An ld write SHALL take effect at the next edge in any state.
REQ-025 If an ld write and a WB write target the same register in one cycle, the WB write SHALL win; different targets SHALL both be written.
REQ-026 A command with rs1 = rs2 = rd SHALL be legal and SHALL read the old value and write back the new one.
REQ-027 The result SHALL be truncated to DATA_W with no carry or flag outputs.
REQ-028 cmd_valid while cmd_ready is 0 SHALL be ignored; the source holds it until accepted.

Reset
REQ-029 While rst is 1, the state SHALL go to IDLE, all rf entries and alu_A, alu_B, alu_instruction, wb_data and wb_rd SHALL clear to 0, and wb_valid and cmd_ready SHALL be 0.
REQ-030 Reset asserted in EXEC or WB SHALL abort the command, suppress its write-back, and ignore any ld write in the reset cycle.

Verification
REQ-031 All scenarios SHALL use an ALU stub with F = A + B (mod 256) for opcode 4'b0000.
REQ-032 ld r1=8'h12 and r2=8'h34, then cmd op=0, rs1=1, rs2=2, rd=3 -> alu_A=8'h12 and alu_B=8'h34 next cycle, wb_valid, wb_rd=3 and wb_data=8'h46 two cycles after the handshake, then dbg r3=8'h46.
REQ-033 r0=8'hFF, cmd rs1=0, rs2=0, rd=0 -> wb_data=8'hFE and r0=8'hFE; cmd_ready is 0 for the 2 cycles after the handshake.
REQ-034 cmd with rd=2 and ld_addr=2, ld_data=8'hAA asserted during the WB cycle -> r2 holds the ALU result, not 8'hAA.
REQ-035 ld r1=8'h05 asserted in the handshake cycle of cmd rs1=1 (old r1=8'h01) -> alu_A=8'h01 and r1=8'h05 afterwards.
REQ-036 rst pulsed in EXEC -> no wb_valid, all registers read 8'h00, and cmd_ready is 1 on the first cycle after rst deasserts.
REQ-037 Back-to-back cmd_valid held high for 9 cycles -> exactly 3 handshakes, spaced 3 cycles apart.
